alu_multicycle: RTL and testbench

//   Parametrised, handshaked ALU for the multi-cycle MIPS datapath. Adds SUB/AND/NOR/SRL/SLT and
//   a registered output. Optionally adds an iterative unsigned multiply producing a 2*DATA_WIDTH

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_shift_add_mul.sv | 88 ++++++++
 rtl/alu_multicycle.sv | 189 ++++++++++++++++++
 tb/tb_alu_multicycle.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the multi-cycle MIPS ALU: 4-bit opcode encodings
//   and the control FSM state encoding.
//   Configuration macro: ALU_MUL_EN (MUL opcode is only honoured when defined).
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_SLL = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_NOR = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// ---------------------------------------------------------------------------
// alu_shift_add_mul
//   Radix-2 shift-add unsigned multiplier, one multiplier bit per cycle.
//   A start pulse loads the operands; DATA_WIDTH cycles later done_o is
//   high for one cycle and product_o carries the full 2*DATA_WIDTH product.
// Ports
//   clk_i, reset_i     clock, synchronous active-high reset (control only)
//   start_i            load operands and begin iterating
//   multiplicand_i     operand A
//   multiplier_i       operand B
//   busy_o             iteration in progress
//   done_o             last iteration cycle; product_o valid
//   product_o          multiplicand * multiplier (valid with done_o)
// ---------------------------------------------------------------------------
module alu_shift_add_mul
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic [DATA_WIDTH-1:0]   multiplicand_i,
   input  logic [DATA_WIDTH-1:0]   multiplier_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [2*DATA_WIDTH-1:0] product_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   logic                    busy_q, busy_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   mcand_q;
   logic [2*DATA_WIDTH-1:0] prod_q;
   logic [2*DATA_WIDTH-1:0] prod_step;
   logic [DATA_WIDTH:0]     upper_sum;

   // prod_q = {partial sum, remaining multiplier bits}; the LSB selects
   // whether the multiplicand is added, then the whole thing shifts right.
   // The adder is one bit wider so its carry lands in the shifted-in MSB.
   always_comb begin
      upper_sum = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_step = {upper_sum, prod_q[DATA_WIDTH-1:1]};
   end

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = CNT_W'(DATA_WIDTH - 1);
      end else if (busy_q) begin
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (start_i) begin
         mcand_q <= multiplicand_i;
         prod_q  <= {{DATA_WIDTH{1'b0}}, multiplier_i};
      end else if (busy_q) begin
         prod_q  <= prod_step;
      end
   end

   assign busy_o    = busy_q;
   // The final product is taken from the combinational step so the top can
   // register it on the same edge that retires the last iteration.
   assign done_o    = busy_q && (cnt_q == '0);
   assign product_o = prod_step;

endmodule

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Handshaked ALU for the multi-cycle MIPS datapath. Single-cycle ops
//   (AND/OR/SLL/ADD/SUB/NOR/SRL/SLT) register their result one cycle after
//   acceptance. With ALU_MUL_EN defined, MUL runs an iterative unsigned
//   multiply and returns {hi_o,result_o} DATA_WIDTH+1 cycles after accept.
//   Configuration macro: ALU_MUL_EN.
// Ports
//   clk, reset     clock, synchronous active-high reset
//   valid_i        request; accepted when valid_i && ready_o
//   alu_op_i       opcode (alu_pkg)
//   a_i, b_i       operands
//   shamt_i        shift amount for SLL/SRL
//   ready_o        idle, can accept this cycle
//   valid_o        one-cycle result strobe
//   result_o       result (low product half for MUL)
//   hi_o           high product half for MUL, else 0
//   zero_o         result_o == 0
//   overflow_o     signed overflow for ADD/SUB
// ---------------------------------------------------------------------------
module alu_multicycle
   import alu_pkg::*;
#(
   parameter  int DATA_WIDTH  = 32,
   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   valid_i,
   input  logic [3:0]             alu_op_i,
   input  logic [DATA_WIDTH-1:0]  a_i,
   input  logic [DATA_WIDTH-1:0]  b_i,
   input  logic [SHAMT_WIDTH-1:0] shamt_i,
   output logic                   ready_o,
   output logic                   valid_o,
   output logic [DATA_WIDTH-1:0]  result_o,
   output logic [DATA_WIDTH-1:0]  hi_o,
   output logic                   zero_o,
   output logic                   overflow_o
);

   function automatic logic add_ovf(input logic signed [DATA_WIDTH-1:0] a,
                                    input logic signed [DATA_WIDTH-1:0] b,
                                    input logic signed [DATA_WIDTH-1:0] s);
      return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
   endfunction

   function automatic logic sub_ovf(input logic signed [DATA_WIDTH-1:0] a,
                                    input logic signed [DATA_WIDTH-1:0] b,
                                    input logic signed [DATA_WIDTH-1:0] d);
      return (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (d[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
   endfunction

   alu_state_e                   state_q, state_d;
   logic                         valid_q, valid_d;
   logic        [DATA_WIDTH-1:0] result_q, result_d;
   logic        [DATA_WIDTH-1:0] hi_q, hi_d;
   logic                         zero_q, zero_d;
   logic                         ovf_q, ovf_d;

   logic signed [DATA_WIDTH-1:0] a_s, b_s, sum_s, diff_s;
   logic        [DATA_WIDTH-1:0] alu_res;
   logic                         alu_ovf;

   assign a_s    = a_i;
   assign b_s    = b_i;
   assign sum_s  = a_s + b_s;
   assign diff_s = a_s - b_s;

   always_comb begin : datapath
      alu_res = '0;
      alu_ovf = 1'b0;
      case (alu_op_i)
         OP_AND: alu_res = a_i & b_i;
         OP_OR:  alu_res = a_i | b_i;
         OP_SLL: alu_res = b_i << shamt_i;
         OP_ADD: begin
            alu_res = sum_s;
            alu_ovf = add_ovf(a_s, b_s, sum_s);
         end
         OP_SUB: begin
            alu_res = diff_s;
            alu_ovf = sub_ovf(a_s, b_s, diff_s);
         end
         OP_NOR: alu_res = ~(a_i | b_i);
         OP_SRL: alu_res = b_i >> shamt_i;
         OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
         default: alu_res = '0;   // unknown opcodes (and MUL when disabled)
      endcase
   end

`ifdef ALU_MUL_EN
   logic                    mul_start;
   logic                    mul_busy;
   logic                    mul_done;
   logic [2*DATA_WIDTH-1:0] mul_prod;

   alu_shift_add_mul #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mul (
      .clk_i          (clk),
      .reset_i        (reset),
      .start_i        (mul_start),
      .multiplicand_i (a_i),
      .multiplier_i   (b_i),
      .busy_o         (mul_busy),
      .done_o         (mul_done),
      .product_o      (mul_prod)
   );
`endif

   always_comb begin : control
      state_d  = state_q;
      valid_d  = 1'b0;
      result_d = result_q;
      hi_d     = hi_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
`ifdef ALU_MUL_EN
      mul_start = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            // ready_o is high in IDLE, so valid_i alone means accept
            if (valid_i) begin
`ifdef ALU_MUL_EN
               if (alu_op_i == OP_MUL) begin
                  state_d   = S_MUL;
                  mul_start = 1'b1;
               end else
`endif
               begin
                  result_d = alu_res;
                  hi_d     = '0;
                  zero_d   = (alu_res == '0);
                  ovf_d    = alu_ovf;
                  valid_d  = 1'b1;
               end
            end
         end
`ifdef ALU_MUL_EN
         S_MUL: begin
            if (mul_done) begin
               state_d  = S_IDLE;
               result_d = mul_prod[DATA_WIDTH-1:0];
               hi_d     = mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
               zero_d   = (mul_prod[DATA_WIDTH-1:0] == '0);
               ovf_d    = 1'b0;
               valid_d  = 1'b1;
            end else if (!mul_busy) begin
               // multiplier went idle without finishing: never wait forever
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         valid_q  <= 1'b0;
         result_q <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ready_o    = (state_q == S_IDLE);
   assign valid_o    = valid_q;
   assign result_o   = result_q;
`ifdef ALU_MUL_EN
   assign hi_o       = hi_q;
`else
   assign hi_o       = '0;
`endif
   assign zero_o     = zero_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

   logic        clk;
   logic        reset;
   logic        valid_i;
   logic [3:0]  alu_op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [4:0]  shamt_i;
   logic        ready_o;
   logic        valid_o;
   logic [31:0] result_o;
   logic [31:0] hi_o;
   logic        zero_o;
   logic        overflow_o;

   int n_cmp  = 0;
   int n_fail = 0;

   alu_multicycle #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (valid_i),
      .alu_op_i   (alu_op_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .shamt_i    (shamt_i),
      .ready_o    (ready_o),
      .valid_o    (valid_o),
      .result_o   (result_o),
      .hi_o       (hi_o),
      .zero_o     (zero_o),
      .overflow_o (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      valid_i  = 1'b1;
      alu_op_i = op;
      a_i      = a;
      b_i      = b;
      shamt_i  = sh;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      valid_i = 1'b0;
      step(); step(); step();
      reset = 1'b0;
      step();
      n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ready_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", valid_o); end
      n_cmp++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result_o); end
      n_cmp++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h want=0", hi_o); end
      n_cmp++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_zero got=%b want=0", zero_o); end
      n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", overflow_o); end
   endtask

   task automatic test_add_overflow();
      drive(4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
      step();
      valid_i = 1'b0;
      n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL add_valid got=%b want=1", valid_o); end
      n_cmp++; if (result_o !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result got=%h want=80000000", result_o); end
      n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL add_ovf got=%b want=1", overflow_o); end
      n_cmp++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL add_zero got=%b want=0", zero_o); end
      step();
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL add_pulse got=%b want=0", valid_o); end
      n_cmp++; if (result_o !== 32'h8000_0000) begin n_fail++; $display("FAIL add_hold got=%h want=80000000", result_o); end
   endtask

   task automatic test_back_to_back();
      drive(4'b0100, 32'd5, 32'd5, 5'd0);
      step();
      n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_valid got=%b want=1", valid_o); end
      n_cmp++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_zero got=%b want=1", zero_o); end
      n_cmp++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL b2b_sub_result got=%h want=0", result_o); end
      n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b want=1", ready_o); end
      drive(4'b0001, 32'h0000_00F0, 32'h0000_0F00, 5'd0);
      step();
      valid_i = 1'b0;
      n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_or_valid got=%b want=1", valid_o); end
      n_cmp++; if (result_o !== 32'h0000_0FF0) begin n_fail++; $display("FAIL b2b_or_result got=%h want=00000ff0", result_o); end
      n_cmp++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL b2b_or_zero got=%b want=0", zero_o); end
      step();
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got=%b want=0", valid_o); end
   endtask

   // vectors issued back-to-back; each result checked the cycle after issue
   task automatic test_ops();
      logic [3:0]  op  [10];
      logic [31:0] a   [10];
      logic [31:0] b   [10];
      logic [4:0]  sh  [10];
      logic [31:0] er  [10];
      logic        ez  [10];
      logic        eo  [10];
      op[0]=4'b0010; a[0]=32'h0;         b[0]=32'h1;         sh[0]=5'd31; er[0]=32'h8000_0000; ez[0]=0; eo[0]=0; // SLL
      op[1]=4'b0111; a[1]=32'hFFFF_FFFF; b[1]=32'h1;         sh[1]=5'd0;  er[1]=32'h1;         ez[1]=0; eo[1]=0; // SLT -1<1
      op[2]=4'b0111; a[2]=32'h1;         b[2]=32'hFFFF_FFFF; sh[2]=5'd0;  er[2]=32'h0;         ez[2]=1; eo[2]=0; // SLT 1<-1
      op[3]=4'b0110; a[3]=32'h0;         b[3]=32'h8000_0000; sh[3]=5'd31; er[3]=32'h1;         ez[3]=0; eo[3]=0; // SRL
      op[4]=4'b0110; a[4]=32'h0;         b[4]=32'hF000_0000; sh[4]=5'd4;  er[4]=32'h0F00_0000; ez[4]=0; eo[4]=0; // SRL zero-fill
      op[5]=4'b0000; a[5]=32'hF0F0_F0F0; b[5]=32'hFF00_FF00; sh[5]=5'd0;  er[5]=32'hF000_F000; ez[5]=0; eo[5]=0; // AND
      op[6]=4'b0101; a[6]=32'hF0F0_F0F0; b[6]=32'h0F0F_0000; sh[6]=5'd0;  er[6]=32'h0000_0F0F; ez[6]=0; eo[6]=0; // NOR
      op[7]=4'b0100; a[7]=32'h8000_0000; b[7]=32'h1;         sh[7]=5'd0;  er[7]=32'h7FFF_FFFF; ez[7]=0; eo[7]=1; // SUB ovf
      op[8]=4'b0011; a[8]=32'hFFFF_FFFF; b[8]=32'h1;         sh[8]=5'd0;  er[8]=32'h0;         ez[8]=1; eo[8]=0; // ADD wrap
      op[9]=4'b1111; a[9]=32'h5;         b[9]=32'h7;         sh[9]=5'd3;  er[9]=32'h0;         ez[9]=1; eo[9]=0; // unknown
      for (int i = 0; i < 10; i++) begin
         drive(op[i], a[i], b[i], sh[i]);
         step();
         n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL op%0d_valid got=%b want=1", i, valid_o); end
         n_cmp++; if (result_o !== er[i]) begin n_fail++; $display("FAIL op%0d_result got=%h want=%h", i, result_o, er[i]); end
         n_cmp++; if (zero_o !== ez[i]) begin n_fail++; $display("FAIL op%0d_zero got=%b want=%b", i, zero_o, ez[i]); end
         n_cmp++; if (overflow_o !== eo[i]) begin n_fail++; $display("FAIL op%0d_ovf got=%b want=%b", i, overflow_o, eo[i]); end
      end
      valid_i = 1'b0;
      step();
   endtask

`ifdef ALU_MUL_EN
   task automatic test_mul_max();
      drive(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      for (int k = 1; k <= 32; k++) begin
         step();
         if (k == 1) valid_i = 1'b0;
         n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL mul_busy_ready T+%0d got=%b want=0", k, ready_o); end
         n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mul_busy_valid T+%0d got=%b want=0", k, valid_o); end
         if (k == 5) drive(4'b0011, 32'h1, 32'h1, 5'd0);
         if (k == 6) valid_i = 1'b0;
      end
      step();
      n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL mul_valid T+33 got=%b want=1", valid_o); end
      n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL mul_ready T+33 got=%b want=1", ready_o); end
      n_cmp++; if (hi_o !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_hi got=%h want=fffffffe", hi_o); end
      n_cmp++; if (result_o !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_lo got=%h want=00000001", result_o); end
      n_cmp++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL mul_zero got=%b want=0", zero_o); end
      step();
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mul_extra_valid got=%b want=0", valid_o); end
      n_cmp++; if (result_o !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_hold got=%h want=00000001", result_o); end
   endtask

   task automatic test_mul_reset();
      bit saw_valid = 1'b0;
      bit saw_busy  = 1'b0;
      drive(4'b1000, 32'h0000_1234, 32'h0000_0010, 5'd0);
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 1) valid_i = 1'b0;
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got=%b want=0", valid_o); end
      n_cmp++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL mrst_result got=%h want=0", result_o); end
      n_cmp++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL mrst_hi got=%h want=0", hi_o); end
      n_cmp++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL mrst_zero got=%b want=0", zero_o); end
      n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL mrst_ready got=%b want=1", ready_o); end
      for (int k = 0; k < 40; k++) begin
         step();
         if (valid_o) saw_valid = 1'b1;
         if (!ready_o) saw_busy = 1'b1;
      end
      n_cmp++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_late_valid got=%b want=0", saw_valid); end
      n_cmp++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL mrst_late_busy got=%b want=0", saw_busy); end
   endtask

   task automatic test_mul_small();
      drive(4'b1000, 32'd3, 32'd4, 5'd0);
      step();
      valid_i = 1'b0;
      for (int k = 2; k <= 33; k++) step();
      n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL mul34_valid got=%b want=1", valid_o); end
      n_cmp++; if (result_o !== 32'd12) begin n_fail++; $display("FAIL mul34_lo got=%h want=0000000c", result_o); end
      n_cmp++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL mul34_hi got=%h want=0", hi_o); end
   endtask
`else
   task automatic test_mul_disabled();
      drive(4'b1000, 32'd3, 32'd4, 5'd0);
      step();
      valid_i = 1'b0;
      n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL nomul_valid got=%b want=1", valid_o); end
      n_cmp++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL nomul_result got=%h want=0", result_o); end
      n_cmp++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL nomul_zero got=%b want=1", zero_o); end
      n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL nomul_ready got=%b want=1", ready_o); end
      n_cmp++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL nomul_hi got=%h want=0", hi_o); end
      step();
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL nomul_pulse got=%b want=0", valid_o); end
   endtask
`endif

   initial begin
      reset    = 1'b1;
      valid_i  = 1'b0;
      alu_op_i = 4'b0000;
      a_i      = '0;
      b_i      = '0;
      shamt_i  = '0;
      test_reset();
      test_add_overflow();
      test_back_to_back();
      test_ops();
`ifdef ALU_MUL_EN
      test_mul_max();
      test_mul_reset();
      test_mul_small();
`else
      test_mul_disabled();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
